// File: rtl/asi_pkg.sv
// Shared definitions for the AXI slave interface blocks: burst and response
// encodings, the write-side FSM state type and burst legality rules.
package asi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } asi_state_e;

  // max_size is log2 of the data bus width in bytes.
  function automatic logic burst_illegal(input int unsigned size,
                                         input int unsigned len,
                                         input int unsigned max_size,
                                         input logic [1:0]  burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    return (size > max_size) || (burst == 2'b11) ||
           ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/asi_addr_gen.sv
// Combinational AXI next-beat address generator (FIXED / INCR / WRAP),
// shared by the write and read slave paths.
module asi_addr_gen import asi_pkg::*; #(
  parameter int AXI_AW = 32,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3
) (
  input  logic [AXI_AW-1:0] addr,
  input  logic [AXI_SW-1:0] size,
  input  logic [AXI_LW-1:0] len,
  input  logic [1:0]        burst,
  output logic [AXI_AW-1:0] next_addr
);

  logic [AXI_AW-1:0] beat_bytes;
  logic [AXI_AW-1:0] aligned;
  logic [AXI_AW-1:0] incr_addr;
  logic [AXI_AW-1:0] wrap_bytes;
  logic [AXI_AW-1:0] wrap_mask;

  always_comb begin
    beat_bytes = AXI_AW'(1) << size;
    aligned    = addr & ~(beat_bytes - AXI_AW'(1));
    incr_addr  = aligned + beat_bytes;
    // Wrap window is (len+1) beats, naturally aligned to its own size.
    wrap_bytes = (AXI_AW'(len) + AXI_AW'(1)) << size;
    wrap_mask  = wrap_bytes - AXI_AW'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/asi_w.sv
// AXI write slave front end: accepts one AW/W burst at a time, turns each
// accepted beat into a registered single-cycle RAM write, then returns B.
module asi_w import asi_pkg::*; #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_WSTRBW = AXI_DW / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // Every channel transfers on the rising edge where VALID and READY are
  // both high; VALID never depends on READY, READY may depend on state only.
  input  logic [AXI_IW-1:0]     AWID,
  input  logic [AXI_AW-1:0]     AWADDR,
  input  logic [AXI_LW-1:0]     AWLEN,
  input  logic [AXI_SW-1:0]     AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [AXI_DW-1:0]     WDATA,
  input  logic [AXI_WSTRBW-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [AXI_IW-1:0]     BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic                  usr_we,
  output logic [AXI_AW-1:0]     usr_waddr,
  output logic [AXI_DW-1:0]     usr_wdata,
  output logic [AXI_WSTRBW-1:0] usr_wstrb,
  output asi_state_e            dbg_state
);

  localparam int unsigned MAX_SIZE = $clog2(AXI_WSTRBW);

  asi_state_e          state;
  asi_state_e          state_nxt;
  logic [AXI_IW-1:0]   id_q;
  logic [AXI_AW-1:0]   addr_q;
  logic [AXI_LW-1:0]   len_q;
  logic [AXI_SW-1:0]   size_q;
  logic [1:0]          burst_q;
  logic [AXI_LW:0]     beat_cnt;
  logic                err_q;
  logic                illegal_q;
  logic                aw_hs;
  logic                w_hs;
  logic                last_beat;
  logic                aw_illegal;
  logic [AXI_AW-1:0]   next_addr;

  assign aw_hs      = AWVALID && AWREADY;
  assign w_hs       = WVALID && WREADY;
  assign last_beat  = (beat_cnt == {1'b0, len_q});
  assign aw_illegal = burst_illegal(32'(AWSIZE), 32'(AWLEN), MAX_SIZE, AWBURST);
  assign dbg_state  = state;

  asi_addr_gen #(
    .AXI_AW (AXI_AW),
    .AXI_LW (AXI_LW),
    .AXI_SW (AXI_SW)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BID       = '0;
    BRESP     = RESP_OKAY;
    case (state)
      ST_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        WREADY = 1'b1;
        // Termination is by beat count alone; WLAST only feeds the error flag.
        if (WVALID && last_beat) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        BVALID = 1'b1;
        BID    = id_q;
        BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (BREADY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
      usr_we    <= 1'b0;
      usr_waddr <= '0;
      usr_wdata <= '0;
      usr_wstrb <= '0;
    end else begin
      usr_we <= 1'b0;
      if (aw_hs) begin
        id_q      <= AWID;
        addr_q    <= AWADDR;
        len_q     <= AWLEN;
        size_q    <= AWSIZE;
        burst_q   <= AWBURST;
        beat_cnt  <= '0;
        illegal_q <= aw_illegal;
        err_q     <= aw_illegal;
      end
      if (w_hs) begin
        beat_cnt <= beat_cnt + (AXI_LW+1)'(1);
        addr_q   <= next_addr;
        if (WLAST != last_beat) err_q <= 1'b1;
        // Illegal bursts are drained without touching the RAM.
        if (!illegal_q) begin
          usr_we    <= 1'b1;
          usr_waddr <= addr_q;
          usr_wdata <= WDATA;
          usr_wstrb <= WSTRB;
        end
      end
    end
  end

endmodule

// File: tb/tb_asi_w.sv
// Directed bench for asi_w: a burst-level address/response model feeds an
// expected-write queue that a per-cycle compare process checks.
module tb_asi_w;
  import asi_pkg::*;

  localparam int EW = 208;  // {due_cycle[31:0], addr[31:0], strb[15:0], data[127:0]}

  logic         ACLK;
  logic         ARESETn;
  logic [7:0]   AWID;
  logic [31:0]  AWADDR;
  logic [7:0]   AWLEN;
  logic [2:0]   AWSIZE;
  logic [1:0]   AWBURST;
  logic         AWVALID;
  logic         AWREADY;
  logic [127:0] WDATA;
  logic [15:0]  WSTRB;
  logic         WLAST;
  logic         WVALID;
  logic         WREADY;
  logic [7:0]   BID;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic         usr_we;
  logic [31:0]  usr_waddr;
  logic [127:0] usr_wdata;
  logic [15:0]  usr_wstrb;
  asi_state_e   dbg_state;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0] obs_addr[$];
  logic [1:0]  last_bresp;

  asi_w dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .usr_we(usr_we), .usr_waddr(usr_waddr), .usr_wdata(usr_wdata),
    .usr_wstrb(usr_wstrb), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got no event, expected event within bound", name);
  endtask

  task automatic obs_is(input string name, input int idx, input logic [31:0] v);
    if (idx < obs_addr.size()) chk(name, obs_addr[idx], v);
    else fail_now(name);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model_addr(input logic [31:0] a, input int size,
                                             input int len, input logic [1:0] burst,
                                             input int n);
    logic [31:0] bytes, aligned, win, base;
    bytes   = 32'd1 << size;
    aligned = a - (a % bytes);
    if (n == 0 || burst == 2'b00) return a;
    if (burst == 2'b10) begin
      win  = 32'(len + 1) * bytes;
      base = a - (a % win);
      return base + ((aligned - base + 32'(n) * bytes) % win);
    end
    return aligned + 32'(n) * bytes;
  endfunction

  function automatic bit model_illegal(input int size, input int len, input logic [1:0] burst);
    return (size > 4) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // ---------------- compare process ----------------
  always @(negedge ACLK) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0 && exp_q[0][207:176] < 32'(cyc)) begin
      fail_now("usr_we_missing");
      void'(exp_q.pop_front());
    end
    if (usr_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL usr_we_unexpected: got usr_we=1 addr %0h, expected usr_we=0", usr_waddr);
      end else begin
        e = exp_q.pop_front();
        chk("we_latency", 32'(cyc), e[207:176]);
        chk("usr_waddr", usr_waddr, e[175:144]);
        chk("usr_wstrb", usr_wstrb, e[143:128]);
        chk("usr_wdata", usr_wdata, e[127:0]);
        obs_addr.push_back(usr_waddr);
      end
    end
  end

  // ---------------- driver tasks (enter and leave just after a negedge) ----------------
  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input int len,
                       input int size, input logic [1:0] burst);
    bit done;
    logic rdy;
    done = 0;
    AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = burst;
    AWVALID = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      rdy = AWREADY;
      @(posedge ACLK);
      @(negedge ACLK);
      if (rdy) done = 1;
    end
    AWVALID = 1'b0;
    if (!done) fail_now("aw_timeout");
  endtask

  task automatic w_beat(input logic [127:0] d, input logic [15:0] s, input logic l,
                        input bit push, input logic [31:0] a);
    bit done;
    logic rdy;
    done = 0;
    WDATA = d; WSTRB = s; WLAST = l; WVALID = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      rdy = WREADY;
      if (rdy) begin
        chk("awready_in_data", AWREADY, 1'b0);
        if (push) exp_q.push_back({32'(cyc + 1), a, s, d});
      end
      @(posedge ACLK);
      @(negedge ACLK);
      if (rdy) done = 1;
    end
    if (!done) fail_now("w_timeout");
  endtask

  task automatic b_phase(input logic [7:0] id, input logic [1:0] resp, input int stall);
    bit seen;
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      if (BVALID === 1'b1) seen = 1;
      else @(negedge ACLK);
    end
    if (!seen) begin
      fail_now("bvalid_timeout");
      return;
    end
    last_bresp = BRESP;
    chk("bid", BID, id);
    chk("bresp", BRESP, resp);
    chk("wready_in_resp", WREADY, 1'b0);
    chk("awready_in_resp", AWREADY, 1'b0);
    repeat (stall) begin
      @(negedge ACLK);
      chk("bvalid_hold", BVALID, 1'b1);
      chk("bid_hold", BID, id);
      chk("bresp_hold", BRESP, resp);
      chk("awready_hold", AWREADY, 1'b0);
    end
    BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("bvalid_after_b", BVALID, 1'b0);
    chk("awready_after_b", AWREADY, 1'b1);
  endtask

  // last_mode: 0 = WLAST on final beat, 1 = WLAST withheld, 2 = extra WLAST on beat 0
  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst, input int last_mode,
                           input int stall, input logic [23:0] tag);
    bit   illegal;
    logic l;
    illegal = model_illegal(size, len, burst);
    do_aw(id, addr, len, size, burst);
    for (int n = 0; n <= len; n++) begin
      case (last_mode)
        1:       l = 1'b0;
        2:       l = (n == len) || (n == 0);
        default: l = (n == len);
      endcase
      w_beat({4{tag, 8'(n)}}, 16'(16'hFFFF >> n), l, !illegal,
             model_addr(addr, size, len, burst, n));
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    b_phase(id, (illegal || last_mode != 0) ? RESP_SLVERR : RESP_OKAY, stall);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    last_bresp = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", AWREADY, 1'b1);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_bid", BID, 8'h00);
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_usr_we", usr_we, 1'b0);
    chk("rst_usr_waddr", usr_waddr, 32'h0);
    chk("rst_usr_wdata", usr_wdata, 128'h0);
    chk("rst_usr_wstrb", usr_wstrb, 16'h0);
    chk("rst_state", dbg_state, ST_IDLE);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // W beats offered while idle must be ignored
    WVALID = 1'b1; WLAST = 1'b1;
    repeat (3) begin
      chk("wready_idle", WREADY, 1'b0);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;

    // INCR 0x1000 x4
    obs_addr.delete();
    run_burst(8'h5A, 32'h1000, 3, 4, BURST_INCR, 0, 0, 24'hA10000);
    chk("incr_count", obs_addr.size(), 4);
    obs_is("incr_a0", 0, 32'h1000);
    obs_is("incr_a1", 1, 32'h1010);
    obs_is("incr_a2", 2, 32'h1020);
    obs_is("incr_a3", 3, 32'h1030);
    chk("incr_bresp_lit", last_bresp, 2'b00);

    // WRAP 0x1038, window 0x1000-0x103F
    obs_addr.delete();
    run_burst(8'h3C, 32'h1038, 3, 4, BURST_WRAP, 0, 0, 24'hB20000);
    obs_is("wrap_a0", 0, 32'h1038);
    obs_is("wrap_a1", 1, 32'h1000);
    obs_is("wrap_a2", 2, 32'h1010);
    obs_is("wrap_a3", 3, 32'h1020);

    // FIXED with WLAST withheld
    obs_addr.delete();
    run_burst(8'h11, 32'h200, 2, 4, BURST_FIXED, 1, 0, 24'hC30000);
    chk("fixed_count", obs_addr.size(), 3);
    obs_is("fixed_a2", 2, 32'h200);
    chk("fixed_bresp_lit", last_bresp, 2'b10);

    // SIZE wider than the bus
    obs_addr.delete();
    run_burst(8'h22, 32'h300, 1, 5, BURST_INCR, 0, 0, 24'hD40000);
    chk("illegal_size_count", obs_addr.size(), 0);
    chk("illegal_size_bresp_lit", last_bresp, 2'b10);

    // B stalled 5 cycles, then a back-to-back WRAP of 8 x 4 bytes
    obs_addr.delete();
    run_burst(8'h77, 32'h2000, 1, 3, BURST_INCR, 0, 5, 24'hE50000);
    obs_is("stall_a1", 1, 32'h2008);
    run_burst(8'h78, 32'h84, 7, 2, BURST_WRAP, 0, 0, 24'hE60000);
    obs_is("b2b_wrap_a0", 2, 32'h84);
    obs_is("b2b_wrap_a6", 8, 32'h9C);
    obs_is("b2b_wrap_a7", 9, 32'h80);

    // early WLAST, unaligned INCR, illegal encodings
    obs_addr.delete();
    run_burst(8'h90, 32'h3004, 2, 2, BURST_INCR, 2, 0, 24'hF70000);
    chk("early_last_count", obs_addr.size(), 3);
    chk("early_last_bresp_lit", last_bresp, 2'b10);
    obs_addr.delete();
    run_burst(8'h93, 32'h1003, 1, 2, BURST_INCR, 0, 0, 24'h180000);
    obs_is("unaligned_a0", 0, 32'h1003);
    obs_is("unaligned_a1", 1, 32'h1004);
    run_burst(8'h91, 32'h100, 0, 2, 2'b11, 0, 0, 24'h290000);
    run_burst(8'h92, 32'h100, 2, 2, BURST_WRAP, 0, 0, 24'h3A0000);

    // reset after beat 1 of an 8-beat burst
    do_aw(8'hAB, 32'h4000, 7, 4, BURST_INCR);
    w_beat({4{32'h4B000000}}, 16'hFFFF, 1'b0, 1, 32'h4000);
    w_beat({4{32'h4B000001}}, 16'hFFFF, 1'b0, 1, 32'h4010);
    WVALID = 1'b0;
    ARESETn = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    chk("rst_mid_usr_we", usr_we, 1'b0);
    chk("rst_mid_bvalid", BVALID, 1'b0);
    chk("rst_mid_awready", AWREADY, 1'b1);
    chk("rst_mid_wready", WREADY, 1'b0);
    chk("rst_mid_state", dbg_state, ST_IDLE);
    chk("rst_mid_pending", exp_q.size(), 0);
    repeat (4) @(negedge ACLK);
    obs_addr.delete();
    run_burst(8'h44, 32'h5000, 1, 4, BURST_INCR, 0, 0, 24'h4C0000);
    obs_is("post_rst_a1", 1, 32'h5010);
    chk("post_rst_bresp_lit", last_bresp, 2'b00);

    repeat (3) @(negedge ACLK);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/asi_w.md
ASI_W -- requirements
Module: asi_w

Interface
REQ-001 Parameters: AXI_DW 128, data bus width; AXI_AW 32, address width; AXI_IW 8, ID width; AXI_LW 8, AWLEN width; AXI_SW 3, AWSIZE width; AXI_WSTRBW AXI_DW/8, strobe width.
REQ-002 ACLK in 1: single clock; all logic on rising edge.
REQ-003 ARESETn in 1: reset, synchronous, active-low.
REQ-004 AWID/AWADDR/AWLEN/AWSIZE/AWBURST in AXI_IW/AXI_AW/AXI_LW/AXI_SW/2: write address payload.
REQ-005 AWVALID in 1, AWREADY out 1: AW handshake.
REQ-006 WDATA in AXI_DW, WSTRB in AXI_WSTRBW, WLAST in 1, WVALID in 1, WREADY out 1: W channel.
REQ-007 BID out AXI_IW, BRESP out 2, BVALID out 1, BREADY in 1: B channel.
REQ-008 usr_we out 1, usr_waddr out AXI_AW, usr_wdata out AXI_DW, usr_wstrb out AXI_WSTRBW: registered single-cycle RAM write port; the RAM always accepts.

Function
REQ-009 FSM states: IDLE, DATA, RESP; no other states reachable.
REQ-010 IDLE: AWREADY=1; AW handshake latches ID, ADDR, LEN, SIZE, BURST, clears beat counter and error flag, enters DATA.
REQ-011 DATA: WREADY=1, AWREADY=0; each W handshake increments beat counter (AXI_LW+1 bits).
REQ-012 Each W handshake drives usr_we=1 next cycle with usr_waddr=current beat address, usr_wdata=WDATA, usr_wstrb=WSTRB; usr_we=0 otherwise; latency exactly 1 cycle.
REQ-013 Burst terminates strictly on beat count = AWLEN+1; that handshake moves DATA->RESP.
REQ-014 WLAST low on the final beat, or high on any earlier beat, sets error flag; beat counting unaffected.
REQ-015 Burst illegal if AWSIZE > log2(AXI_WSTRBW), AWBURST=2'b11, or WRAP with AWLEN not in {1,3,7,15}; illegal bursts still consume AWLEN+1 beats with usr_we held 0 and error flag set.
REQ-016 Beat address: beat 0 = AWADDR unmodified; FIXED: every beat = AWADDR; INCR: beat n = (AWADDR aligned to 2^AWSIZE) + n*2^AWSIZE, modulo 2^AXI_AW; WRAP: wrap window of (AWLEN+1)*2^AWSIZE bytes aligned to that size, address wraps to window base on reaching window top.
REQ-017 RESP: BVALID=1, BID=latched AWID, BRESP=2'b10 (SLVERR) if error flag else 2'b00 (OKAY); held stable until BREADY.
REQ-018 BVALID&&BREADY -> IDLE next cycle; AWREADY high the cycle after the B handshake; one outstanding transaction only.
REQ-019 W beats presented while in IDLE or RESP are not accepted (WREADY=0); AW presented outside IDLE is not accepted.
REQ-020 No 4KB-boundary checking; no exclusive access; EXOKAY never returned.

Reset
REQ-021 ARESETn low at a clock edge: state=IDLE, AWREADY=1 and WREADY=0 from the following cycle, BVALID=0, BID=0, BRESP=0, usr_we=0, usr_waddr=0, usr_wdata=0, usr_wstrb=0, counters and error flag 0.
REQ-022 Reset mid-burst or mid-response abandons the transaction: no B response, no further usr_we.

Structure
REQ-023 Package asi_pkg holds burst encodings (FIXED 2'b00, INCR 2'b01, WRAP 2'b10), response constants (OKAY, EXOKAY, SLVERR, DECERR), and the FSM state enum.
REQ-024 Next-address computation lives in sub-module asi_addr_gen (combinational: addr, size, len, burst -> next addr), reusable by the future read-side block.

Verification
REQ-025 INCR: AWADDR=0x1000, LEN=3, SIZE=4, BURST=INCR, WLAST on beat 3 -> usr_waddr 0x1000,0x1010,0x1020,0x1030 one cycle after each W handshake; BRESP=OKAY, BID=AWID.
REQ-026 WRAP: AWADDR=0x1038, LEN=3, SIZE=4 -> usr_waddr 0x1038,0x1000,0x1010,0x1020 (beat 0 unaligned, window 0x1000-0x103F); OKAY.
REQ-027 FIXED: AWADDR=0x200, LEN=2, SIZE=4 -> three usr_we at 0x200; WLAST withheld on beat 2 -> BRESP=SLVERR after exactly 3 beats.
REQ-028 Illegal: SIZE=5 with AXI_DW=128, LEN=1 -> 2 W beats accepted, usr_we never asserted, BRESP=SLVERR.
REQ-029 BREADY held low 5 cycles -> BVALID, BID, BRESP stable; AWREADY stays 0 until cycle after B handshake; back-to-back AW accepted then.
REQ-030 ARESETn pulsed low after beat 1 of LEN=7 burst -> usr_we=0, BVALID=0, AWREADY=1 next cycle; new burst completes normally.
